// File: rtl/arg_parse_sequencer_pkg.sv
// Shared types for the argument sequencer: the character type, the argument-slot enum,
// the sequencer states, and the mapping from slot to argument title.
package arg_parse_sequencer_pkg;

  typedef logic [7:0] Char_t;

  localparam Char_t CHAR_X = 8'h58;
  localparam Char_t CHAR_Y = 8'h59;
  localparam Char_t CHAR_I = 8'h49;
  localparam Char_t CHAR_J = 8'h4A;

  localparam int unsigned NUM_ARGS = 4;

  typedef enum logic [1:0] {
    ARG_X,
    ARG_Y,
    ARG_I,
    ARG_J
  } ArgSlot_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WAIT_RDY,
    ST_TRIGGER,
    ST_WAIT_DONE,
    ST_STORE,
    ST_FINISH
  } seq_state_t;

  function automatic Char_t slot_title(input ArgSlot_t slot);
    Char_t c;
    case (slot)
      ARG_X:   c = CHAR_X;
      ARG_Y:   c = CHAR_Y;
      ARG_I:   c = CHAR_I;
      ARG_J:   c = CHAR_J;
      default: c = CHAR_X;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/arg_parse_sequencer_fsm.sv
// Control FSM for the argument sequencer: state register plus upstream/downstream handshake outputs.
module arg_parse_sequencer_fsm
  import arg_parse_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       trigger,
  input  logic       sub_rdy,
  input  logic       sub_done,
  input  logic       sub_success,
  input  logic       any_left,
  input  logic       last_slot,
  output seq_state_t state,
  output logic       rdy,
  output logic       done,
  output logic       sub_trigger
);

  seq_state_t state_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rdy         = 1'b0;
    done        = 1'b0;
    sub_trigger = 1'b0;
    case (state)
      ST_IDLE: begin
        rdy  = 1'b1;
        done = 1'b1;
        if (trigger) state_nxt = ST_SELECT;
      end
      ST_SELECT:    state_nxt = any_left ? ST_WAIT_RDY : ST_FINISH;
      ST_WAIT_RDY:  if (sub_rdy) state_nxt = ST_TRIGGER;
      ST_TRIGGER: begin
        sub_trigger = 1'b1;
        if (!sub_rdy) state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: if (sub_done) state_nxt = ST_STORE;
      // A failed run means the subparser already consumed the rest of the line.
      ST_STORE:     state_nxt = (!sub_success || last_slot) ? ST_FINISH : ST_SELECT;
      ST_FINISH: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:      state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/arg_parse_sequencer.sv
// Walks the expected-argument mask of one G-code line, running the argument subparser once per
// expected slot (X, Y, I, J in order) and collecting values, valid flags and error flags.
module arg_parse_sequencer
  import arg_parse_sequencer_pkg::*;
#(
  parameter int unsigned NUM_WIDTH = 16,
  parameter int unsigned NUM_ARGS  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clk_en,
  input  logic                                trigger,
  input  logic [NUM_ARGS-1:0]                 arg_mask,
  output logic                                rdy,
  output logic                                done,
  output logic                                sub_trigger,
  output Char_t                               sub_title,
  input  logic                                sub_rdy,
  input  logic                                sub_done,
  input  logic                                sub_success,
  input  logic                                sub_too_big,
  input  logic [NUM_WIDTH-1:0]                sub_value,
  output logic [NUM_ARGS-1:0][NUM_WIDTH-1:0]  arg_values,
  output logic [NUM_ARGS-1:0]                 arg_valid,
  output logic                                err_missing,
  output logic                                err_too_big
);

  localparam int unsigned IDX_W = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;

  seq_state_t          state;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    next_idx;
  logic [NUM_ARGS-1:0] mask;
  logic                any_left;
  logic                last_slot;

  arg_parse_sequencer_fsm u_fsm (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .trigger     (trigger),
    .sub_rdy     (sub_rdy),
    .sub_done    (sub_done),
    .sub_success (sub_success),
    .any_left    (any_left),
    .last_slot   (last_slot),
    .state       (state),
    .rdy         (rdy),
    .done        (done),
    .sub_trigger (sub_trigger)
  );

  // Lowest expected slot at or above the current index.
  always_comb begin
    any_left = 1'b0;
    next_idx = idx;
    for (int unsigned i = 0; i < NUM_ARGS; i++) begin
      if (!any_left && mask[i] && (i >= 32'(idx))) begin
        any_left = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

  assign last_slot = (idx == IDX_W'(NUM_ARGS - 1));
  assign sub_title = slot_title(ArgSlot_t'(idx));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      mask        <= '0;
      arg_values  <= '0;
      arg_valid   <= '0;
      err_missing <= 1'b0;
      err_too_big <= 1'b0;
    end else if (clk_en) begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            mask        <= arg_mask;
            idx         <= '0;
            arg_values  <= '0;
            arg_valid   <= '0;
            err_missing <= 1'b0;
            err_too_big <= 1'b0;
          end
        end
        ST_SELECT: begin
          if (any_left) idx <= next_idx;
        end
        ST_STORE: begin
          if (sub_success) begin
            arg_values[idx] <= sub_value;
            arg_valid[idx]  <= 1'b1;
            if (!last_slot) idx <= idx + IDX_W'(1);
          end else begin
            err_missing <= 1'b1;
          end
          if (sub_too_big) err_too_big <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arg_parse_sequencer.sv
// Scoreboard bench for arg_parse_sequencer with a behavioural argument-subparser model.
module tb_arg_parse_sequencer;
  import arg_parse_sequencer_pkg::*;

  logic              clk = 1'b0;
  logic              reset, clk_en, trigger;
  logic [3:0]        arg_mask;
  logic              rdy, done, sub_trigger;
  Char_t             sub_title;
  logic              sub_rdy, sub_done, sub_success, sub_too_big;
  logic [15:0]       sub_value;
  logic [3:0][15:0]  arg_values;
  logic [3:0]        arg_valid;
  logic              err_missing, err_too_big;

  typedef struct {
    bit          ok;
    bit          big;
    logic [15:0] val;
  } resp_t;

  typedef struct {
    bit          is_title;
    logic [7:0]  title;
    logic [63:0] vals;
    logic [3:0]  valid;
    bit          em;
    bit          eb;
  } exp_t;

  exp_t  exp_q[$];
  resp_t resp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    trig_seen = 0;

  always #5 clk = ~clk;

  arg_parse_sequencer #(.NUM_WIDTH(16), .NUM_ARGS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .trigger     (trigger),
    .arg_mask    (arg_mask),
    .rdy         (rdy),
    .done        (done),
    .sub_trigger (sub_trigger),
    .sub_title   (sub_title),
    .sub_rdy     (sub_rdy),
    .sub_done    (sub_done),
    .sub_success (sub_success),
    .sub_too_big (sub_too_big),
    .sub_value   (sub_value),
    .arg_values  (arg_values),
    .arg_valid   (arg_valid),
    .err_missing (err_missing),
    .err_too_big (err_too_big)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push_title(input logic [7:0] c);
    exp_t e;
    e = '{is_title: 1'b1, title: c, vals: '0, valid: '0, em: 1'b0, eb: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic push_result(input logic [63:0] v, input logic [3:0] vl, input bit em, input bit eb);
    exp_t e;
    e = '{is_title: 1'b0, title: '0, vals: v, valid: vl, em: em, eb: eb};
    exp_q.push_back(e);
  endtask

  task automatic push_resp(input bit ok, input bit big, input logic [15:0] val);
    resp_t r;
    r = '{ok: ok, big: big, val: val};
    resp_q.push_back(r);
  endtask

  // Subparser model: drops rdy after seeing a trigger, answers two cycles later and holds the result.
  initial begin
    resp_t r;
    sub_rdy = 1'b1; sub_done = 1'b0; sub_success = 1'b0; sub_too_big = 1'b0; sub_value = '0;
    forever begin
      @(posedge clk);
      if (!reset && clk_en && sub_trigger) begin
        #1;
        sub_rdy  = 1'b0;
        sub_done = 1'b0;
        if (resp_q.size() > 0) r = resp_q.pop_front();
        else r = '{ok: 1'b0, big: 1'b0, val: 16'h0};
        repeat (2) @(posedge clk);
        #1;
        sub_success = r.ok;
        sub_too_big = r.big;
        sub_value   = r.val;
        sub_done    = 1'b1;
        sub_rdy     = 1'b1;
      end
    end
  end

  // Monitor: a new sub_trigger checks the issued title, the FINISH cycle checks the line result.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
        continue;
      end
      if (sub_trigger && !prev) begin
        trig_seen++;
        if (exp_q.size() == 0 || !exp_q[0].is_title) begin
          total++; bad++;
          $display("FAIL unexpected_trigger: title %h issued, no title expected", sub_title);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          e = exp_q.pop_front();
          chk("title", 64'(sub_title), 64'(e.title));
        end
      end
      if (done && !rdy) begin
        if (exp_q.size() == 0 || exp_q[0].is_title) begin
          total++; bad++;
          $display("FAIL unexpected_finish: valid %b, no result expected", arg_valid);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          e = exp_q.pop_front();
          chk("arg_values", 64'(arg_values), e.vals);
          chk("arg_valid", 64'(arg_valid), 64'(e.valid));
          chk("err_missing", 64'(err_missing), 64'(e.em));
          chk("err_too_big", 64'(err_too_big), 64'(e.eb));
        end
      end
      prev = sub_trigger;
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && rdy) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL timeout_%s: %0d expectations pending, rdy=%b", name, exp_q.size(), rdy);
      exp_q.delete();
    end
  endtask

  task automatic start_line(input logic [3:0] m);
    @(posedge clk); #1;
    arg_mask = m;
    trigger  = 1'b1;
    @(posedge clk); #1;
    trigger  = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; clk_en = 1'b1; trigger = 1'b0; arg_mask = '0;
    #2;
    chk("reset_rdy", 64'(rdy), 64'd1);
    chk("reset_done", 64'(done), 64'd1);
    chk("reset_sub_trigger", 64'(sub_trigger), 64'd0);
    chk("reset_values", 64'(arg_values), 64'd0);
    chk("reset_valid", 64'(arg_valid), 64'd0);
    chk("reset_errs", 64'({err_missing, err_too_big}), 64'd0);
    @(negedge clk); reset = 1'b0;

    // X=100, Y=-50
    push_title(CHAR_X); push_title(CHAR_Y);
    push_resp(1'b1, 1'b0, 16'd100); push_resp(1'b1, 1'b0, 16'hFFCE);
    push_result(64'h0000_0000_FFCE_0064, 4'b0011, 1'b0, 1'b0);
    start_line(4'b0011); wait_idle("xy");
    chk("hold_valid_after_finish", 64'(arg_valid), 64'h3);

    // X and I only, Y skipped
    push_title(CHAR_X); push_title(CHAR_I);
    push_resp(1'b1, 1'b0, 16'h0123); push_resp(1'b1, 1'b0, 16'h7FFF);
    push_result(64'h0000_7FFF_0000_0123, 4'b0101, 1'b0, 1'b0);
    start_line(4'b0101); wait_idle("xi");

    // Y missing: sequencing stops, slot 1 keeps its cleared value
    push_title(CHAR_X); push_title(CHAR_Y);
    push_resp(1'b1, 1'b0, 16'd5); push_resp(1'b0, 1'b0, 16'hBEEF);
    push_result(64'h0000_0000_0000_0005, 4'b0001, 1'b1, 1'b0);
    start_line(4'b0011); wait_idle("missing");

    // Overflow still stores the value
    push_title(CHAR_X);
    push_resp(1'b1, 1'b1, 16'h8000);
    push_result(64'h0000_0000_0000_8000, 4'b0001, 1'b0, 1'b1);
    start_line(4'b0001); wait_idle("too_big");

    // All four slots, last slot ends the line without wrapping
    push_title(CHAR_X); push_title(CHAR_Y); push_title(CHAR_I); push_title(CHAR_J);
    push_resp(1'b1, 1'b0, 16'd1); push_resp(1'b1, 1'b0, 16'd2);
    push_resp(1'b1, 1'b0, 16'd3); push_resp(1'b1, 1'b0, 16'd4);
    push_result(64'h0004_0003_0002_0001, 4'b1111, 1'b0, 1'b0);
    start_line(4'b1111); wait_idle("xyij");

    // J alone
    push_title(CHAR_J);
    push_resp(1'b1, 1'b0, 16'h1234);
    push_result(64'h1234_0000_0000_0000, 4'b1000, 1'b0, 1'b0);
    start_line(4'b1000); wait_idle("j_only");

    // Empty mask: SELECT then FINISH
    push_result(64'h0, 4'b0000, 1'b0, 1'b0);
    start_line(4'b0000);
    chk("mask0_cycle1_done", 64'({rdy, done}), 64'b00);
    @(posedge clk); #1;
    chk("mask0_cycle2_done", 64'({rdy, done}), 64'b01);
    wait_idle("mask0");

    // Empty mask with clk_en low for 5 cycles while in SELECT
    push_result(64'h0, 4'b0000, 1'b0, 1'b0);
    start_line(4'b0000);
    clk_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("freeze_state", 64'({rdy, done}), 64'b00);
    clk_en = 1'b1;
    @(posedge clk); #1;
    chk("unfreeze_finish", 64'({rdy, done}), 64'b01);
    wait_idle("freeze");

    // Reset while waiting on the Y subparser run
    push_title(CHAR_X); push_title(CHAR_Y);
    push_resp(1'b1, 1'b0, 16'd7); push_resp(1'b1, 1'b0, 16'd8);
    n = trig_seen;
    start_line(4'b0011);
    for (int k = 0; k < 100 && trig_seen < n + 2; k++) begin @(posedge clk); #1; end
    for (int k = 0; k < 100 && sub_trigger; k++) begin @(posedge clk); #1; end
    chk("pre_reset_valid", 64'(arg_valid), 64'h1);
    reset = 1'b1;
    #1;
    chk("midreset_rdy_done", 64'({rdy, done}), 64'b11);
    chk("midreset_valid", 64'(arg_valid), 64'h0);
    chk("midreset_sub_trigger", 64'(sub_trigger), 64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("leftover_expectations", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
